// File: rtl/main_fsm.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and mux select except imm_src.
module main_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pc_update,
  output logic       branch,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_UTYPE    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t state_q, state_d;

  logic pc_update_c, branch_c, ir_write_c, reg_write_c, mem_write_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_update_c   = 1'b0;
    branch_c      = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    mem_write_c   = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        result_src  = 2'b10;
        alu_src_b   = 2'b10;
        ir_write_c  = mem_ready;
        pc_update_c = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_UTYPE;
          default: begin
            state_d       = S_FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch_c  = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_UTYPE: begin
        result_src  = 2'b11;
        reg_write_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset holds state at FETCH, so only the mem_ready-driven enables need masking;
  // all write enables are gated for safety.
  assign pc_update = pc_update_c & rst_n;
  assign branch    = branch_c    & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign state     = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: table of per-cycle {op, mem_ready, state, outputs}
// vectors plus hand-written reset sequences.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       mem_ready = 1'b0;
  logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       illegal_instr;
  logic [3:0] state;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_update(pc_update), .branch(branch), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_instr(illegal_instr), .state(state)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Output word: pcu br irw rw mw adr | rs[1:0] asa[1:0] asb[1:0] aop[1:0] | ill
  localparam logic [14:0] O_FRDY = 15'b101000_10_00_10_00_0;
  localparam logic [14:0] O_FWT  = 15'b000000_10_00_10_00_0;
  localparam logic [14:0] O_DEC  = 15'b000000_00_01_01_00_0;
  localparam logic [14:0] O_DILL = 15'b000000_00_01_01_00_1;
  localparam logic [14:0] O_MADR = 15'b000000_00_10_01_00_0;
  localparam logic [14:0] O_MRD  = 15'b000001_00_00_00_00_0;
  localparam logic [14:0] O_MWB  = 15'b000100_01_00_00_00_0;
  localparam logic [14:0] O_MWR  = 15'b000011_00_00_00_00_0;
  localparam logic [14:0] O_EXR  = 15'b000000_00_10_00_10_0;
  localparam logic [14:0] O_EXI  = 15'b000000_00_10_01_10_0;
  localparam logic [14:0] O_AWB  = 15'b000100_00_00_00_00_0;
  localparam logic [14:0] O_BEQ  = 15'b010000_00_10_00_01_0;
  localparam logic [14:0] O_JAL  = 15'b100000_00_01_10_00_0;
  localparam logic [14:0] O_UTY  = 15'b000100_11_00_00_00_0;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] outs;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [18:0] observed();
    return {state, pc_update, branch, ir_write, reg_write, mem_write, adr_src,
            result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                  name, act[18:15], act[14:0], exp[18:15], exp[14:0]);
  endtask

  task automatic add(input logic [6:0] o, input logic m, input logic [3:0] s,
                     input logic [14:0] w);
    vec_t v;
    v.op = o; v.mr = m; v.st = s; v.outs = w;
    exp_q.push_back(v);
  endtask

  initial begin
    // lw: 0,1,2,3,4
    add(LW,1,0,O_FRDY); add(LW,1,1,O_DEC); add(LW,1,2,O_MADR);
    add(LW,1,3,O_MRD);  add(LW,1,4,O_MWB);
    // sw with two wait cycles in MEMWRITE
    add(SW,1,0,O_FRDY); add(SW,1,1,O_DEC); add(SW,1,2,O_MADR);
    add(SW,0,5,O_MWR);  add(SW,0,5,O_MWR); add(SW,1,5,O_MWR);
    // R-type, I-type
    add(RT,1,0,O_FRDY); add(RT,1,1,O_DEC); add(RT,1,6,O_EXR); add(RT,1,8,O_AWB);
    add(IT,1,0,O_FRDY); add(IT,1,1,O_DEC); add(IT,1,7,O_EXI); add(IT,1,8,O_AWB);
    // beq, jal, lui
    add(BQ,1,0,O_FRDY); add(BQ,1,1,O_DEC); add(BQ,1,9,O_BEQ);
    add(JL,1,0,O_FRDY); add(JL,1,1,O_DEC); add(JL,1,10,O_JAL); add(JL,1,8,O_AWB);
    add(LU,1,0,O_FRDY); add(LU,1,1,O_DEC); add(LU,1,11,O_UTY);
    // illegal opcode: flagged only in DECODE, straight back to FETCH
    add(BAD,1,0,O_FRDY); add(BAD,1,1,O_DILL);
    // fetch stall of three cycles
    add(RT,0,0,O_FWT); add(RT,0,0,O_FWT); add(RT,0,0,O_FWT);
    add(RT,1,0,O_FRDY); add(RT,1,1,O_DEC); add(RT,1,6,O_EXR); add(RT,1,8,O_AWB);
    // lw with MEMREAD stall while op changes underneath
    add(LW,1,0,O_FRDY); add(LW,1,1,O_DEC); add(LW,1,2,O_MADR);
    add(SW,0,3,O_MRD);  add(BAD,0,3,O_MRD); add(BAD,1,3,O_MRD); add(BAD,1,4,O_MWB);
    add(BAD,0,0,O_FWT);

    // Reset at time zero, before any clock edge
    mem_ready = 1'b1;
    #1;
    check("reset_initial", observed(), {4'd0, O_FWT});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < exp_q.size(); i++) begin
      if (i != 0) @(negedge clk);
      op = exp_q[i].op;
      mem_ready = exp_q[i].mr;
      #1;
      check($sformatf("vec%0d", i), observed(), {exp_q[i].st, exp_q[i].outs});
    end

    // Reset mid-MEMREAD: state drops to FETCH asynchronously, enables stay 0
    @(negedge clk); op = LW; mem_ready = 1'b1;   // FETCH
    @(negedge clk);                              // DECODE
    @(negedge clk); mem_ready = 1'b0;            // MEMADR
    @(negedge clk);                              // MEMREAD
    #1;
    check("pre_reset_memread", observed(), {4'd3, O_MRD});
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("async_reset", observed(), {4'd0, O_FWT});
    @(posedge clk); #1;
    check("reset_held_edge", observed(), {4'd0, O_FWT});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_fetch", observed(), {4'd0, O_FRDY});
    @(negedge clk); #1;
    check("release_decode", observed(), {4'd1, O_DEC});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1);
  end

endmodule
